// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, WORD_WIDTH data bits LSB first, stop bit.
// Bit timing comes from an internal divider producing 16 oversample ticks per bit.
module uart_tx_serializer #(
   parameter int WORD_WIDTH = 8,
   parameter int SB_TICKS   = 16,
   parameter int DIVISOR    = 163
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_tx_start,
   input  logic [WORD_WIDTH-1:0] i_tx_data,
   output logic                  o_tx,
   output logic                  o_tx_ready,
   output logic                  o_tx_done
);

   localparam int DIV_W  = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
   localparam int TICK_W = $clog2(SB_TICKS);
   localparam int BIT_W  = $clog2(WORD_WIDTH);

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIVISOR - 1);
   localparam logic [TICK_W-1:0] BIT_TICKS = TICK_W'(15);
   localparam logic [TICK_W-1:0] SB_LAST   = TICK_W'(SB_TICKS - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t                r_state;
   logic [DIV_W-1:0]      r_div;
   logic [TICK_W-1:0]     r_tickCnt;
   logic [BIT_W-1:0]      r_bitCnt;
   logic [WORD_WIDTH-1:0] r_shift;
   logic                  r_tx;
   logic                  r_ready;
   logic                  r_done;
   logic                  w_tick;

   assign w_tick     = (r_div == DIV_LAST);
   assign o_tx       = r_tx;
   assign o_tx_ready = r_ready;
   assign o_tx_done  = r_done;

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_state   <= IDLE;
         r_div     <= '0;
         r_tickCnt <= '0;
         r_bitCnt  <= '0;
         r_shift   <= '0;
         r_tx      <= 1'b1;
         r_ready   <= 1'b1;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         // The divider free-runs during a frame and is parked at zero while idle.
         if (r_state != IDLE) begin
            r_div <= w_tick ? '0 : r_div + 1'b1;
         end
         case (r_state)
            IDLE: begin
               r_tx <= 1'b1;
               if (i_tx_start) begin
                  r_shift   <= i_tx_data;
                  r_state   <= START;
                  r_tx      <= 1'b0;
                  r_ready   <= 1'b0;
                  r_div     <= '0;
                  r_tickCnt <= '0;
                  r_bitCnt  <= '0;
               end
            end
            START: begin
               if (w_tick) begin
                  if (r_tickCnt == BIT_TICKS) begin
                     r_tickCnt <= '0;
                     r_state   <= DATA;
                     r_tx      <= r_shift[0];
                  end else begin
                     r_tickCnt <= r_tickCnt + 1'b1;
                  end
               end
            end
            DATA: begin
               if (w_tick) begin
                  if (r_tickCnt == BIT_TICKS) begin
                     r_tickCnt <= '0;
                     if (r_bitCnt == BIT_LAST) begin
                        r_state <= STOP;
                        r_tx    <= 1'b1;
                     end else begin
                        // Next line level is the bit that becomes the LSB after this shift.
                        r_bitCnt <= r_bitCnt + 1'b1;
                        r_shift  <= r_shift >> 1;
                        r_tx     <= r_shift[1];
                     end
                  end else begin
                     r_tickCnt <= r_tickCnt + 1'b1;
                  end
               end
            end
            STOP: begin
               if (w_tick) begin
                  if (r_tickCnt == SB_LAST) begin
                     r_tickCnt <= '0;
                     r_state   <= IDLE;
                     r_ready   <= 1'b1;
                     r_done    <= 1'b1;
                  end else begin
                     r_tickCnt <= r_tickCnt + 1'b1;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
               r_tx    <= 1'b1;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Randomized self-checking bench for uart_tx_serializer; expected line levels are
// computed from frame arithmetic (bit index = clocks since acceptance / clocks per bit).
module tb_uart_tx_serializer;

   localparam int DIV   = 2;
   localparam int WIDTH = 8;
   localparam int FRAME16 = (16 * (1 + WIDTH) + 16) * DIV;
   localparam int FRAME32 = (16 * (1 + WIDTH) + 32) * DIV;

   logic             clock;
   logic             resetN;
   logic             txStart;
   logic [WIDTH-1:0] txData;
   logic             tx;
   logic             txReady;
   logic             txDone;

   logic             txStart32;
   logic [WIDTH-1:0] txData32;
   logic             tx32;
   logic             txReady32;
   logic             txDone32;

   int checks;
   int errors;

   uart_tx_serializer #(.WORD_WIDTH(WIDTH), .SB_TICKS(16), .DIVISOR(DIV)) dut (
      .i_clock(clock), .i_reset(resetN), .i_tx_start(txStart), .i_tx_data(txData),
      .o_tx(tx), .o_tx_ready(txReady), .o_tx_done(txDone)
   );

   uart_tx_serializer #(.WORD_WIDTH(WIDTH), .SB_TICKS(32), .DIVISOR(DIV)) dut32 (
      .i_clock(clock), .i_reset(resetN), .i_tx_start(txStart32), .i_tx_data(txData32),
      .o_tx(tx32), .o_tx_ready(txReady32), .o_tx_done(txDone32)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Expected line level k clocks after the acceptance edge: start, data LSB first, stop, idle.
   function automatic logic expTx(input logic [WIDTH-1:0] d, input int k, input int sbTicks);
      int bitLen;
      int frameLen;
      int idx;
      bitLen   = 16 * DIV;
      frameLen = (16 * (1 + WIDTH) + sbTicks) * DIV;
      if (k >= frameLen) return 1'b1;
      idx = k / bitLen;
      if (idx == 0) return 1'b0;
      if (idx <= WIDTH) return d[idx-1];
      return 1'b1;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic waitReady();
      int n;
      n = 0;
      while (txReady !== 1'b1 && n < 2000) begin
         @(posedge clock); #1;
         n++;
      end
      checkOutput("readyBeforeStart", {31'd0, txReady}, 32'd1);
   endtask

   // Sends one frame on the main DUT and checks every clock of it. busyAt injects an
   // ignored start (data 0xFF) at that clock; chain holds start high with nextData so the
   // following frame is accepted right after the done cycle; chained skips the handshake.
   task automatic applyStimulus(input logic [WIDTH-1:0] d, input int busyAt, input bit chain,
                                input logic [WIDTH-1:0] nextData, input bit chained);
      if (!chained) begin
         waitReady();
         txStart = 1'b1;
         txData  = d;
      end
      @(posedge clock); #1;
      for (int k = 0; k <= FRAME16; k++) begin
         checkOutput($sformatf("tx[%02h]@%0d", d, k), {31'd0, tx}, {31'd0, expTx(d, k, 16)});
         checkOutput($sformatf("ready[%02h]@%0d", d, k), {31'd0, txReady}, {31'd0, k >= FRAME16});
         checkOutput($sformatf("done[%02h]@%0d", d, k), {31'd0, txDone}, {31'd0, k == FRAME16});
         txData  = WIDTH'($urandom);
         txStart = 1'b0;
         if (k == busyAt) begin
            txStart = 1'b1;
            txData  = 8'hFF;
         end
         if (chain) begin
            txStart = 1'b1;
            txData  = nextData;
         end
         if (k < FRAME16) begin
            @(posedge clock); #1;
         end
      end
   endtask

   initial begin
      int donePulses;
      logic [WIDTH-1:0] d;
      checks    = 0;
      errors    = 0;
      txStart   = 1'b0;
      txData    = '0;
      txStart32 = 1'b0;
      txData32  = '0;
      resetN    = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      checkOutput("resetTx", {31'd0, tx}, 32'd1);
      checkOutput("resetReady", {31'd0, txReady}, 32'd1);
      checkOutput("resetDone", {31'd0, txDone}, 32'd0);
      resetN = 1'b1;

      // Idle must persist with data wiggling but no start request.
      for (int i = 0; i < 20; i++) begin
         txData = WIDTH'($urandom);
         @(posedge clock); #1;
         checkOutput($sformatf("idleTx@%0d", i), {31'd0, tx}, 32'd1);
         checkOutput($sformatf("idleReady@%0d", i), {31'd0, txReady}, 32'd1);
      end

      $display("[TB] single byte 0x01");
      applyStimulus(8'h01, -1, 1'b0, 8'h00, 1'b0);
      $display("[TB] busy start ignored during 0xA5");
      applyStimulus(8'hA5, 100, 1'b0, 8'h00, 1'b0);
      $display("[TB] back-to-back 0x02 then 0x08");
      applyStimulus(8'h02, -1, 1'b1, 8'h08, 1'b0);
      applyStimulus(8'h08, -1, 1'b0, 8'h00, 1'b1);
      $display("[TB] data churn during 0x3C");
      applyStimulus(8'h3C, -1, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 4; i++) begin
         d = WIDTH'($urandom);
         $display("[TB] random frame %02h", d);
         applyStimulus(d, int'($urandom_range(0, FRAME16 - 1)), 1'b0, 8'h00, 1'b0);
      end

      $display("[TB] reset abort mid 0x55 frame");
      waitReady();
      txStart = 1'b1;
      txData  = 8'h55;
      @(posedge clock); #1;
      txStart = 1'b0;
      repeat (40) @(posedge clock);
      #2;
      resetN = 1'b0;
      #1;
      checkOutput("abortTx", {31'd0, tx}, 32'd1);
      checkOutput("abortReady", {31'd0, txReady}, 32'd1);
      checkOutput("abortDone", {31'd0, txDone}, 32'd0);
      @(posedge clock); #2;
      resetN = 1'b1;
      donePulses = 0;
      for (int i = 0; i < FRAME16 + 40; i++) begin
         @(posedge clock); #1;
         if (txDone === 1'b1) donePulses++;
         checkOutput($sformatf("abortIdle@%0d", i), {31'd0, tx}, 32'd1);
      end
      checkOutput("abortDonePulses", donePulses, 32'd0);

      $display("[TB] stop length with SB_TICKS=32");
      d = WIDTH'($urandom);
      txStart32 = 1'b1;
      txData32  = d;
      @(posedge clock); #1;
      for (int k = 0; k <= FRAME32; k++) begin
         checkOutput($sformatf("tx32[%02h]@%0d", d, k), {31'd0, tx32}, {31'd0, expTx(d, k, 32)});
         checkOutput($sformatf("ready32@%0d", k), {31'd0, txReady32}, {31'd0, k >= FRAME32});
         checkOutput($sformatf("done32@%0d", k), {31'd0, txDone32}, {31'd0, k == FRAME32});
         txStart32 = 1'b0;
         txData32  = WIDTH'($urandom);
         if (k < FRAME32) begin
            @(posedge clock); #1;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
